stopwatch_lap_ctrl: RTL

STOPWATCH_LAP_CTRL -- requirements
Module: stopwatch_lap_ctrl

---
 rtl/stopwatch_lap_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch with lap capture: a BCD count advanced by a 10 ms prescaler, plus a
// free-running writer that mirrors the running and lap times into a character RAM.
module stopwatch_lap_ctrl #(
  parameter int CLK_DIV   = 500000,
  parameter int DIGITS    = 5,
  parameter int MAIN_ADDR = 0,
  parameter int LAP_ADDR  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       lap,
  output logic       we,
  output logic [5:0] write_address,
  output logic [7:0] ram_in,
  output logic       running,
  output logic       overflow
);

  localparam int PW    = $clog2(CLK_DIV);
  localparam int CW    = DIGITS * 4;
  localparam int SEQ_N = 2 * (DIGITS + 1);
  localparam int SW    = $clog2(SEQ_N);
  localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_DIV - 1);
  localparam logic [5:0]    MAIN_BASE = 6'(MAIN_ADDR % 64);
  localparam logic [5:0]    LAP_BASE  = 6'(LAP_ADDR % 64);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

  state_t        state_reg;
  logic [PW-1:0] presc_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] lap_reg;
  logic          overflow_reg;
  logic          running_reg;

  logic          tick;
  logic [CW-1:0] count_next;
  logic          all_nines;

  assign tick = (state_reg == S_RUN) && (presc_reg == PRE_LAST);

  // Ripple decimal increment; the carry surviving the top digit means all-9s.
  always_comb begin
    logic c;
    c          = 1'b1;
    count_next = count_reg;
    for (int k = 0; k < DIGITS; k++) begin
      if (c) begin
        if (count_reg[k*4 +: 4] == 4'd9) begin
          count_next[k*4 +: 4] = 4'd0;
        end else begin
          count_next[k*4 +: 4] = count_reg[k*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    all_nines = c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      presc_reg    <= '0;
      count_reg    <= '0;
      lap_reg      <= '0;
      overflow_reg <= 1'b0;
      running_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          presc_reg <= '0;
          if (start_stop) begin
            state_reg   <= S_RUN;
            running_reg <= 1'b1;
          end
        end
        S_RUN: begin
          if (tick) begin
            presc_reg <= '0;
            if (all_nines) begin
              overflow_reg <= 1'b1;
              state_reg    <= S_STOP;
              running_reg  <= 1'b0;
            end else begin
              count_reg <= count_next;
            end
          end else begin
            presc_reg <= presc_reg + PW'(1);
          end
          // Captures the pre-increment value when a tick lands on the same cycle.
          if (lap && !start_stop) lap_reg <= count_reg;
          if (start_stop) begin
            state_reg   <= S_STOP;
            running_reg <= 1'b0;
          end
        end
        S_STOP: begin
          if (start_stop && !overflow_reg) begin
            state_reg   <= S_RUN;
            running_reg <= 1'b1;
          end else if (lap) begin
            state_reg    <= S_IDLE;
            presc_reg    <= '0;
            count_reg    <= '0;
            lap_reg      <= '0;
            overflow_reg <= 1'b0;
          end
        end
        default: begin
          state_reg   <= S_IDLE;
          running_reg <= 1'b0;
        end
      endcase
    end
  end

  assign running  = running_reg;
  assign overflow = overflow_reg;

  logic [SW-1:0] seq_reg;
  logic          started_reg;
  logic          we_reg;
  logic [5:0]    addr_reg;
  logic [7:0]    char_reg;

  logic          lap_field;
  logic [SW-1:0] pos;
  logic [SW-1:0] dig_idx;
  logic [CW-1:0] src;
  logic [3:0]    digit;
  logic [7:0]    char_next;
  logic [5:0]    addr_next;

  always_comb begin
    lap_field = (seq_reg > SW'(DIGITS));
    pos       = lap_field ? (seq_reg - SW'(DIGITS + 1)) : seq_reg;
    src       = lap_field ? lap_reg : count_reg;
    addr_next = (lap_field ? LAP_BASE : MAIN_BASE) + 6'(pos);
    dig_idx   = (pos < SW'(DIGITS - 2)) ? (SW'(DIGITS - 1) - pos) : (SW'(DIGITS) - pos);
    digit     = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (dig_idx == SW'(k)) digit = src[k*4 +: 4];
    end
    char_next = (pos == SW'(DIGITS - 2)) ? 8'h2E : {4'h3, digit};
  end

  // The first cycle after reset release only arms the writer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      started_reg <= 1'b0;
      seq_reg     <= '0;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      char_reg    <= '0;
    end else begin
      started_reg <= 1'b1;
      if (started_reg) begin
        we_reg   <= 1'b1;
        addr_reg <= addr_next;
        char_reg <= char_next;
        seq_reg  <= (seq_reg == SW'(SEQ_N - 1)) ? '0 : seq_reg + SW'(1);
      end
    end
  end

  assign we            = we_reg;
  assign write_address = addr_reg;
  assign ram_in        = char_reg;

endmodule
